seq_shifter: RTL and testbench



---
 rtl/alu_shift_pkg.sv | 19 +
 rtl/seq_shifter_shift_step.sv | 44 ++++
 rtl/seq_shifter.sv | 94 +++++++++
 tb/tb_seq_shifter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// Shared definitions for the sequential shifter datapath.
//   sh_mode_e : shift/rotate mode encodings as carried on the 2-bit mode bus
//   state_e   : control FSM states of seq_shifter
package alu_shift_pkg;

  typedef enum logic [1:0] {
    SH_LSR    = 2'b00,  // logical right, zero fill
    SH_RFILL1 = 2'b01,  // right, ones fill
    SH_LSL    = 2'b10,  // logical left, zero fill
    SH_ROR    = 2'b11   // rotate right
  } sh_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// shift_step: combinational single-position shift/rotate.
//   data  (in)  : current word
//   mode  (in)  : sh_mode_e encoding
//   next  (out) : word after one step
//   carry (out) : bit that left the word on this step
module shift_step
  import alu_shift_pkg::*;
#(
  parameter int unsigned ancho = 4
) (
  input  logic [ancho-1:0] data,
  input  logic [1:0]       mode,
  output logic [ancho-1:0] next,
  output logic             carry
);

  always_comb begin
    next  = data;
    carry = 1'b0;
    case (sh_mode_e'(mode))
      SH_LSR: begin
        carry = data[0];
        next  = {1'b0, data[ancho-1:1]};
      end
      SH_RFILL1: begin
        carry = data[0];
        next  = {1'b1, data[ancho-1:1]};
      end
      SH_LSL: begin
        carry = data[ancho-1];
        next  = {data[ancho-2:0], 1'b0};
      end
      SH_ROR: begin
        carry = data[0];
        next  = {data[0], data[ancho-1:1]};
      end
      default: begin
        next  = data;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter/rotator, one bit position per clock.
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : request, sampled only while idle
//   a, b, mode      : operand, unsigned shift amount, sh_mode_e mode
//   busy            : high whenever the FSM is not idle
//   done            : one-cycle pulse, aluresult/aluflags freshly valid
//   aluresult       : registered result, held until the next done
//   aluflags        : carry, last bit shifted/rotated out (0 when b=0)
module seq_shifter
  import alu_shift_pkg::*;
#(
  parameter int unsigned ancho = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ancho-1:0] a,
  input  logic [ancho-1:0] b,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [ancho-1:0] aluresult,
  output logic             aluflags
);

  state_e           state;
  logic [ancho-1:0] data;
  logic [ancho-1:0] cnt;
  sh_mode_e         mode_r;
  logic             carry;

  logic [ancho-1:0] step_data;
  logic             step_carry;

  shift_step #(.ancho(ancho)) u_step (
    .data  (data),
    .mode  (mode_r),
    .next  (step_data),
    .carry (step_carry)
  );

  // busy and done are registered alongside the state so that they track
  // state != IDLE and state == DONE without any input-to-output path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      data      <= '0;
      cnt       <= '0;
      mode_r    <= SH_LSR;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aluresult <= '0;
      aluflags  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            data   <= a;
            cnt    <= b;
            mode_r <= sh_mode_e'(mode);
            carry  <= 1'b0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            data  <= step_data;
            carry <= step_carry;
            cnt   <= cnt - ancho'(1);
          end else begin
            aluresult <= data;
            aluflags  <= carry;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] mode;
  logic       busy;
  logic       done;
  logic [3:0] aluresult;
  logic       aluflags;

  int errors = 0;
  int checks = 0;

  seq_shifter #(.ancho(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .aluresult (aluresult),
    .aluflags  (aluflags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Closed-form reference: whole-word arithmetic shifts, not bit stepping.
  function automatic void ref_model(input int ta, input int tb, input int tm,
                                    output logic [3:0] res, output logic fl);
    int x;
    int r;
    case (tm)
      0: begin
        res = 4'((ta >> tb) & 15);
        fl  = (tb == 0) ? 1'b0 : 1'((ta >> (tb - 1)) & 1);
      end
      1: begin
        x   = ta | 32'hFFFF_FFF0;
        res = 4'((x >> tb) & 15);
        fl  = (tb == 0) ? 1'b0 : 1'((x >> (tb - 1)) & 1);
      end
      2: begin
        res = 4'((ta << tb) & 15);
        fl  = (tb == 0) ? 1'b0 : 1'(((ta << tb) >> 4) & 1);
      end
      default: begin
        r   = tb % 4;
        res = 4'(((ta >> r) | (ta << (4 - r))) & 15);
        fl  = (tb == 0) ? 1'b0 : res[3];
      end
    endcase
  endfunction

  // Drives one operation and measures it; comparisons are done by callers.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic [1:0] tm,
                        input bit poke,
                        output logic [3:0] res, output logic fl, output int lat,
                        output int bcnt, output int dcnt, output bit tout);
    bit ended;
    res = '0; fl = 1'b0; lat = -1; bcnt = 0; dcnt = 0; tout = 1'b0; ended = 1'b0;
    a = ta; b = tb; mode = tm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 4'($urandom); b = 4'($urandom); mode = 2'($urandom);
    for (int k = 0; k < 40 && !ended; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (done) begin
        dcnt++;
        if (lat < 0) begin lat = k; res = aluresult; fl = aluflags; end
      end
      if (poke && k == 1) begin
        a = 4'hF; b = 4'h3; mode = 2'b10; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      else ended = 1'b1;
    end
    start = 1'b0;
    if (!ended) tout = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; a = 4'hA; b = 4'h1; mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, aluresult, aluflags} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b res=%b fl=%b, want all 0",
               busy, done, aluresult, aluflags);
    end
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [3:0] ta [6] = '{4'b1011, 4'b0100, 4'b1011, 4'b0001, 4'b1001, 4'b1001};
    logic [3:0] tb [6] = '{4'b0010, 4'b0001, 4'b0001, 4'b0101, 4'b0000, 4'b0000};
    logic [1:0] tm [6] = '{2'b00,   2'b01,   2'b10,   2'b11,   2'b01,   2'b11};
    logic [3:0] er [6] = '{4'b0010, 4'b1010, 4'b0110, 4'b1000, 4'b1001, 4'b1001};
    logic       ef [6] = '{1'b1,    1'b0,    1'b1,    1'b1,    1'b0,    1'b0};
    logic [3:0] res; logic fl; int lat, bcnt, dcnt; bit tout;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], tm[i], 1'b0, res, fl, lat, bcnt, dcnt, tout);
      checks++;
      if (tout || lat != int'(tb[i]) + 1 || dcnt != 1) begin
        errors++;
        $display("FAIL dir%0d_timing: got lat=%0d dones=%0d tout=%0b, want lat=%0d dones=1",
                 i, lat, dcnt, tout, int'(tb[i]) + 1);
      end
      checks++;
      if (res !== er[i] || fl !== ef[i]) begin
        errors++;
        $display("FAIL dir%0d_result: got res=%b fl=%b, want res=%b fl=%b",
                 i, res, fl, er[i], ef[i]);
      end
      checks++;
      if (bcnt != int'(tb[i]) + 2) begin
        errors++;
        $display("FAIL dir%0d_busy: got %0d busy cycles, want %0d", i, bcnt, int'(tb[i]) + 2);
      end
      checks++;
      if (aluresult !== er[i] || aluflags !== ef[i]) begin
        errors++;
        $display("FAIL dir%0d_hold: got res=%b fl=%b after done, want res=%b fl=%b",
                 i, aluresult, aluflags, er[i], ef[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [3:0] res; logic fl; int lat, bcnt, dcnt, extra; bit tout;
    run_op(4'b1001, 4'b0000, 2'b10, 1'b1, res, fl, lat, bcnt, dcnt, tout);
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    checks++;
    if (tout || dcnt != 1 || extra != 0 || lat != 1) begin
      errors++;
      $display("FAIL ignore_start: got dones=%0d extra=%0d lat=%0d tout=%0b, want dones=1 extra=0 lat=1",
               dcnt, extra, lat, tout);
    end
    checks++;
    if (res !== 4'b1001 || fl !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_result: got res=%b fl=%b, want res=1001 fl=0", res, fl);
    end
  endtask

  task automatic test_random();
    logic [3:0] ta, tb, res, eres; logic [1:0] tm; logic fl, efl;
    int lat, bcnt, dcnt; bit tout;
    for (int i = 0; i < 40; i++) begin
      ta = 4'($urandom); tb = 4'($urandom); tm = 2'($urandom);
      ref_model(int'(ta), int'(tb), int'(tm), eres, efl);
      run_op(ta, tb, tm, 1'b0, res, fl, lat, bcnt, dcnt, tout);
      checks++;
      if (tout || res !== eres || fl !== efl || lat != int'(tb) + 1 || bcnt != int'(tb) + 2) begin
        errors++;
        $display("FAIL rand%0d a=%b b=%b m=%b: got res=%b fl=%b lat=%0d busy=%0d, want res=%b fl=%b lat=%0d busy=%0d",
                 i, ta, tb, tm, res, fl, lat, bcnt, eres, efl, int'(tb) + 1, int'(tb) + 2);
      end
    end
  endtask

  task automatic test_reset_abort();
    int dcnt;
    a = 4'b1111; b = 4'b1111; mode = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, aluresult, aluflags} !== 7'b0) begin
      errors++;
      $display("FAIL reset_abort: got busy=%b done=%b res=%b fl=%b, want all 0",
               busy, done, aluresult, aluflags);
    end
    rst_n = 1'b1;
    dcnt = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL reset_abort_quiet: got %0d cycles with busy/done, want 0", dcnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] res, eres; logic fl, efl; int lat, bcnt, dcnt; bit tout;
    for (int i = 0; i < 4; i++) begin
      ref_model(5 + i, i + 1, i, eres, efl);
      run_op(4'(5 + i), 4'(i + 1), 2'(i), 1'b0, res, fl, lat, bcnt, dcnt, tout);
      checks++;
      if (tout || res !== eres || fl !== efl || lat != i + 2) begin
        errors++;
        $display("FAIL b2b%0d: got res=%b fl=%b lat=%0d, want res=%b fl=%b lat=%0d",
                 i, res, fl, lat, eres, efl, i + 2);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; mode = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
